// File: rtl/fir_sequencer_if.sv
// fir_sequencer_if: sample stream in, fir control/capture, result stream out, status.
interface fir_sequencer_if #(
  parameter int IN_W = 16,
  parameter int ACC_W = 39,
  parameter int OUT_W = 32
);
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in_sample;
  logic fir_ena;
  logic [IN_W-1:0] fir_sample;
  logic [ACC_W-1:0] fir_out;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] out_data;
  logic out_sat;
  logic [15:0] sat_count;
  logic busy;
  modport master (
    output in_valid, in_sample, fir_out, out_ready,
    input in_ready, fir_ena, fir_sample, out_valid, out_data, out_sat, sat_count, busy
  );
  modport slave (
    input in_valid, in_sample, fir_out, out_ready,
    output in_ready, fir_ena, fir_sample, out_valid, out_data, out_sat, sat_count, busy
  );
endinterface

// File: rtl/fir_sequencer.sv
// fir_sequencer: paces samples into the fir, waits out its latency, saturates the
// captured accumulator and streams every DECIM-th result downstream.
module fir_sequencer #(
  parameter int IN_W = 16,
  parameter int ACC_W = 39,
  parameter int OUT_W = 32,
  parameter int LATENCY = 1,
  parameter int DECIM = 1
) (
  input logic clk,
  input logic rst,
  fir_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, HOLD} state_t;
  localparam logic signed [ACC_W-1:0] P_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] P_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [7:0] r_phase;
  logic [IN_W-1:0] r_sample;
  logic [OUT_W-1:0] r_data;
  logic r_sat;
  logic r_valid;
  logic [15:0] r_sat_cnt;
  logic w_hi, w_lo, w_clip, w_capture, w_last;
  logic w_ena, w_in_ready, w_busy;
  logic [OUT_W-1:0] w_cap;
  assign w_hi = $signed(bus.fir_out) > P_MAX;
  assign w_lo = $signed(bus.fir_out) < P_MIN;
  assign w_clip = w_hi | w_lo;
  assign w_cap = w_hi ? {1'b0, {(OUT_W-1){1'b1}}} : w_lo ? {1'b1, {(OUT_W-1){1'b0}}} : bus.fir_out[OUT_W-1:0];
  assign w_capture = r_state == SETTLE && r_cnt == 4'd0;
  assign w_last = r_phase == 8'(DECIM - 1);
  always_comb begin
    w_next = r_state;
    w_ena = r_state == SHIFT;
    w_in_ready = r_state == IDLE && rst;
    w_busy = r_state != IDLE;
    case (r_state)
      IDLE: w_next = bus.in_valid ? SHIFT : IDLE;
      SHIFT: w_next = SETTLE;
      SETTLE: w_next = w_capture ? (w_last ? HOLD : IDLE) : SETTLE;
      HOLD: w_next = bus.out_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_phase <= '0;
      r_sample <= '0;
      r_data <= '0;
      r_sat <= 1'b0;
      r_valid <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.in_valid) r_sample <= bus.in_sample;
      if (r_state == SHIFT) r_cnt <= 4'(LATENCY - 1);
      else if (r_state == SETTLE && !w_capture) r_cnt <= r_cnt - 4'd1;
      // every capture counts toward sat_count, including decimated-away ones
      if (w_capture && w_clip && r_sat_cnt != 16'hFFFF) r_sat_cnt <= r_sat_cnt + 16'd1;
      if (w_capture) r_phase <= w_last ? 8'd0 : r_phase + 8'd1;
      if (w_capture && w_last) begin
        r_data <= w_cap;
        r_sat <= w_clip;
        r_valid <= 1'b1;
      end else if (r_state == HOLD && bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign bus.in_ready = w_in_ready;
  assign bus.fir_ena = w_ena;
  assign bus.fir_sample = r_sample;
  assign bus.out_valid = r_valid;
  assign bus.out_data = r_data;
  assign bus.out_sat = r_sat;
  assign bus.sat_count = r_sat_cnt;
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: three sequencer instances (different LATENCY/DECIM) driven by a
// latency-accurate fir stand-in, checked by a scoreboard against a saturation model.
module tb_fir_sequencer;
  localparam int N = 3;
  function automatic int lat_of(input int k);
    return k == 0 ? 1 : k == 1 ? 2 : 4;
  endfunction
  function automatic int dec_of(input int k);
    return k == 1 ? 4 : k == 2 ? 2 : 1;
  endfunction
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] rst, in_valid, ord, rr, rnd;
  logic [N-1:0] in_ready, fir_ena, out_valid, out_ready, out_sat, busy;
  logic [15:0] in_sample [N];
  logic [38:0] nxt_fir [N];
  logic [15:0] fir_sample [N];
  logic [31:0] out_data [N];
  logic [15:0] sat_count [N];
  logic [38:0] bnd [4] = '{39'h00_7FFF_FFFF, 39'h00_8000_0000, 39'h7F_8000_0000, 39'h7F_7FFF_FFFF};
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt [N];
  int ena_cnt [N];
  int hs_cnt [N];
  int satm [N];
  event final_ev;
  assign out_ready = (rr & rnd) | (~rr & ord);
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at cycle %0d", name, k, act, exp, cyc);
    end
  endtask

  // {clipped, 32-bit result} of a signed 39-bit accumulator
  function automatic logic [32:0] ref_sat(input logic [38:0] f);
    longint s;
    s = longint'($signed(f));
    if (s > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, 32'(s)};
  endfunction

  for (genvar g = 0; g < N; g++) begin : inst
    localparam int LAT = lat_of(g);
    localparam int DEC = dec_of(g);
    logic [38:0] fo = '0;
    logic [38:0] v = '0;
    logic [32:0] r, e, held;
    logic ena_d = 1'b0;
    logic ena_prev = 1'b0;
    logic valid_prev = 1'b0;
    logic stall_prev = 1'b0;
    int k = 100;
    int n = 0;
    int last_acc = 0;
    logic [32:0] exp_q [$];
    logic [15:0] sq [$];
    logic [38:0] fq [$];
    fir_sequencer_if bus ();
    fir_sequencer #(.LATENCY(LAT), .DECIM(DEC)) dut (.clk(clk), .rst(rst[g]), .bus(bus));
    assign bus.in_valid = in_valid[g];
    assign bus.in_sample = in_sample[g];
    assign bus.fir_out = fo;
    assign bus.out_ready = out_ready[g];
    assign in_ready[g] = bus.in_ready;
    assign fir_ena[g] = bus.fir_ena;
    assign fir_sample[g] = bus.fir_sample;
    assign out_valid[g] = bus.out_valid;
    assign out_data[g] = bus.out_data;
    assign out_sat[g] = bus.out_sat;
    assign sat_count[g] = bus.sat_count;
    assign busy[g] = bus.busy;
    // fir stand-in: the result is valid only in the single cycle the sequencer should capture it
    initial forever begin
      @(posedge clk);
      #1;
      k = ena_d ? 0 : k + 1;
      fo = (k == LAT - 1) ? v : 39'({$urandom, $urandom});
      rnd[g] = 1'($urandom_range(0, 1));
    end
    always @(negedge clk) begin
      if (!rst[g]) begin
        exp_q.delete();
        sq.delete();
        fq.delete();
        n = 0;
        satm[g] = 0;
        ena_d = 1'b0;
        ena_prev = 1'b0;
        valid_prev = 1'b0;
        stall_prev = 1'b0;
      end else begin
        chk("ready_vs_busy", g, in_ready[g], !busy[g]);
        ena_d = fir_ena[g];
        if (fir_ena[g]) begin
          ena_cnt[g]++;
          chk("ena_twice", g, ena_prev, 0);
          chk("ena_pending", g, sq.size(), 1);
          if (sq.size() > 0) begin
            chk("fir_sample", g, fir_sample[g], sq.pop_front());
            v = fq.pop_front();
          end
        end
        ena_prev = fir_ena[g];
        if (in_valid[g] && in_ready[g]) begin
          acc_cnt[g]++;
          n++;
          last_acc = cyc;
          sq.push_back(in_sample[g]);
          fq.push_back(nxt_fir[g]);
          r = ref_sat(nxt_fir[g]);
          if (r[32]) satm[g]++;
          if (n % DEC == 0) exp_q.push_back(r);
        end
        if (out_valid[g] && !valid_prev) chk("latency", g, cyc - last_acc, LAT + 2);
        if (stall_prev) begin
          chk("hold_valid", g, out_valid[g], 1);
          chk("hold_data", g, {out_sat[g], out_data[g]}, held);
          chk("hold_ena", g, fir_ena[g], 0);
        end
        if (out_valid[g] && out_ready[g]) begin
          hs_cnt[g]++;
          chk("out_expected", g, exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", g, out_data[g], e[31:0]);
            chk("out_sat", g, out_sat[g], e[32]);
          end
        end
        valid_prev = out_valid[g];
        stall_prev = out_valid[g] && !out_ready[g];
        held = {out_sat[g], out_data[g]};
      end
    end
    initial begin
      @(final_ev);
      chk("drain", g, exp_q.size(), 0);
      chk("sat_count", g, sat_count[g], satm[g]);
      chk("ena_count", g, ena_cnt[g], acc_cnt[g]);
    end
  end

  task automatic send(input int k, input logic [15:0] s, input logic [38:0] f);
    int t;
    t = 0;
    in_sample[k] = s;
    nxt_fir[k] = f;
    in_valid[k] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready[k] && t < 200);
    chk("accept_timeout", k, in_ready[k], 1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy[k] || out_valid[k]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", k, busy[k] || out_valid[k], 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [38:0] rnd_fir();
    case ($urandom_range(0, 3))
      0: return 39'(longint'($signed($urandom)));
      1: return {1'b0, 38'({$urandom, $urandom})};
      2: return {1'b1, 38'({$urandom, $urandom})};
      default: return bnd[$urandom_range(0, 3)];
    endcase
  endfunction

  initial begin
    int base, t;
    rst = '0;
    in_valid = '1;
    ord = '1;
    rr = '0;
    for (int i = 0; i < N; i++) begin
      in_sample[i] = '0;
      nxt_fir[i] = '0;
      acc_cnt[i] = 0;
      ena_cnt[i] = 0;
      hs_cnt[i] = 0;
      satm[i] = 0;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_in_ready", i, in_ready[i], 0);
      chk("rst_fir_ena", i, fir_ena[i], 0);
      chk("rst_out_valid", i, out_valid[i], 0);
      chk("rst_sat_count", i, sat_count[i], 0);
      chk("rst_busy", i, busy[i], 0);
    end
    @(posedge clk);
    #1;
    rst = '1;
    in_valid = '0;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("post_rst_ready", i, in_ready[i], 1);
    @(posedge clk);
    #1;
    send(0, 16'h1234, 39'd1000);
    wait_idle(0);
    chk("single_data", 0, out_data[0], 32'd1000);
    send(0, 16'h0001, 39'h3F_FFFF_FFFF);
    wait_idle(0);
    chk("satpos_data", 0, out_data[0], 32'h7FFF_FFFF);
    send(0, 16'h0002, 39'h40_0000_0000);
    wait_idle(0);
    chk("satneg_data", 0, out_data[0], 32'h8000_0000);
    send(0, 16'h0003, 39'h7F_8000_0000);
    wait_idle(0);
    chk("minneg_data", 0, out_data[0], 32'h8000_0000);
    chk("minneg_sat", 0, out_sat[0], 0);
    chk("sat_count_dir", 0, sat_count[0], 2);
    // backpressure: result stalls in HOLD while the next sample waits upstream
    ord[0] = 1'b0;
    send(0, 16'hAAAA, 39'd5);
    in_sample[0] = 16'hBBBB;
    nxt_fir[0] = 39'h7F_FFFF_FFF9;
    in_valid[0] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid[0] && t < 50);
    chk("bp_valid", 0, out_valid[0], 1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_ready", 0, in_ready[0], 0);
      chk("bp_ena", 0, fir_ena[0], 0);
    end
    @(posedge clk);
    #1;
    ord[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_idle", 0, busy[0], 0);
    chk("release_ready", 0, in_ready[0], 1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("release_accept", 0, fir_ena[0], 1);
    wait_idle(0);
    // decimation by 4: eight samples, two results
    base = hs_cnt[1];
    for (int i = 0; i < 8; i++) send(1, 16'($urandom), 39'(longint'($signed($urandom))));
    wait_idle(1);
    chk("decim_hs", 1, hs_cnt[1] - base, 2);
    chk("decim_ena", 1, ena_cnt[1], 8);
    // reset during the second SETTLE cycle, with the decimation phase at 1
    send(2, 16'h0101, 39'd77);
    wait_idle(2);
    chk("phase_no_out", 2, hs_cnt[2], 0);
    send(2, 16'h0202, 39'd88);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 2, busy[2], 0);
    chk("midrst_valid", 2, out_valid[2], 0);
    chk("midrst_ready", 2, in_ready[2], 1);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_quiet", 2, out_valid[2], 0);
    end
    @(posedge clk);
    #1;
    base = hs_cnt[2];
    send(2, 16'h0303, 39'd99);
    wait_idle(2);
    chk("midrst_first", 2, hs_cnt[2] - base, 0);
    send(2, 16'h0404, 39'h3F_0000_0000);
    wait_idle(2);
    chk("midrst_second", 2, hs_cnt[2] - base, 1);
    chk("midrst_data", 2, out_data[2], 32'h7FFF_FFFF);
    // randomized traffic with random downstream stalls
    for (int k = 0; k < N; k++) begin
      rr[k] = 1'b1;
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(k, 16'($urandom), rnd_fir());
      end
      wait_idle(k);
      rr[k] = 1'b0;
    end
    ->final_ev;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
Sample-rate controller sitting in front of the fir block. It accepts input samples over a valid/ready stream and pulses fir ena once per accepted sample. It then waits out the FIR output latency and captures the 39-bit accumulator. The capture is saturated to a 32-bit result, optionally decimated, and presented on a valid/ready output stream with saturation statistics.

Parameters:
IN_W, 16, sample width (matches fir sample port)
ACC_W, 39, fir out width
OUT_W, 32, output word width; signed saturation target
LATENCY, 1, edges from the FIR ena-sampling edge to a valid fir out (legal 1..15)
DECIM, 1, emit every DECIM-th capture (legal 1..256)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-low reset
in_valid  in  1  upstream sample valid
in_ready  out  1  high only in IDLE and only while rst is high
in_sample  in  IN_W  signed input sample
fir_ena  out  1  connects to fir ena
fir_sample  out  IN_W  connects to fir sample; registered
fir_out  in  ACC_W  signed fir out
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  saturated signed result
out_sat  out  1  out_data was clipped
sat_count  out  16  captures clipped since reset; saturates at 16'hFFFF
busy  out  1  state != IDLE

Behaviour:
- Reset (rst low at a posedge):
  - Forces state=IDLE, decimation phase=0, settle counter=0.
  - Clears fir_ena, fir_sample, out_valid, out_data, out_sat and sat_count to 0.
  - An in-flight sample is dropped and emits no output.
  - The FIR reset is not driven by this block.
- FSM states: IDLE, SHIFT, SETTLE, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: fir_sample<=in_sample, go to SHIFT.
- SHIFT:
  - Lasts exactly one cycle; fir_ena=1; fir_sample stable.
  - The edge ending SHIFT (E1) is the FIR shift edge.
  - Go to SETTLE with counter=LATENCY-1.
- SETTLE:
  - fir_ena=0.
  - Counts down; when counter==0, fir_out is captured at that edge (E1+LATENCY).
  - Saturation on capture:
    - fir_out > 2^(OUT_W-1)-1 gives max positive.
    - fir_out < -2^(OUT_W-1) gives min negative.
    - Otherwise take the low OUT_W bits (sign-correct).
    - A clipped capture sets sat flag and increments sat_count (stops at 16'hFFFF).
    - sat_count counts every capture, including decimated-away ones.
  - If phase==DECIM-1: phase<=0, out_data/out_sat<=capture, out_valid<=1, go to HOLD.
  - Else: phase<=phase+1, go to IDLE, no output.
- HOLD:
  - out_valid=1; out_data/out_sat stable; in_ready=0.
  - On out_ready: out_valid<=0, go to IDLE.
  - No same-cycle input accept (one bubble).
- Latency: accept edge E0 to out_valid high after edge E0+LATENCY+1.
- Minimum sample period: LATENCY+2 cycles without output, LATENCY+3 with output and out_ready=1.
- fir_ena is never high outside SHIFT and never high for two consecutive cycles.
- in_valid while not in_ready is ignored; upstream holds the sample.
- out_ready outside HOLD is ignored.
- fir_sample holds its last value between samples.

Test Plan:
- Reset:
  - Stimulus: rst=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0, fir_ena=0, out_valid=0, sat_count=0, busy=0; in_ready=1 in the first cycle after rst=1.
- Single sample (LATENCY=1, DECIM=1):
  - Stimulus: in_sample=16'h1234; fir model returns 39'd1000.
  - Required: fir_ena high exactly 1 cycle with fir_sample=16'h1234; out_valid after edge E0+2; out_data=32'd1000, out_sat=0.
- Saturation:
  - Stimulus: fir_out = 39'h3F_FFFF_FFFF, then 39'h40_0000_0000, then -2147483648.
  - Required, in order:
    - 32'h7FFFFFFF, out_sat=1.
    - 32'h80000000, out_sat=1.
    - 32'h80000000, out_sat=0.
  - Final sat_count=2.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles in HOLD, in_valid=1 throughout.
  - Required while stalled: out_valid/out_data stable, in_ready=0, fir_ena=0.
  - Required on release: out_ready=1 gives IDLE next cycle and the next sample accepted one cycle later.
- Decimation (DECIM=4, LATENCY=2):
  - Stimulus: 8 samples back-to-back.
  - Required: 8 fir_ena pulses; exactly 2 out_valid handshakes carrying captures 4 and 8.
- Reset mid-operation (LATENCY=4):
  - Stimulus: rst=0 during the second SETTLE cycle.
  - Required: state IDLE, no out_valid, phase=0; the next sample behaves as the first after reset.
